// File: rtl/shift_reg.sv
// shift_reg
//   WIDTH-bit serial-in/serial-out shift register with parallel load and
//   parallel readout. The shift strobe (clk) is not a clock here: it is
//   sampled on masterClk, edge-detected, and each rising edge becomes a
//   one-cycle shift pulse. serialInput is sampled through the same number
//   of stages as clk, so each data bit stays aligned with its strobe edge.
//
//   Configuration macro: SHIFTREG_INPUT_SYNC_EN
//     defined   : clk/serialInput pass SYNC_STAGES flops (asynchronous strobe)
//     undefined : a single register stage (strobe synchronous to masterClk)
//
// Ports
//   masterClk      in   system clock, all state updates on its rising edge
//   rst            in   synchronous active-high reset
//   clk            in   shift strobe, one shift per rising edge
//   serialInput    in   serial data, enters bit 0
//   enableShift    in   1 = strobe edges shift, 0 = edges dropped
//   load           in   level, register <= parallelInput every cycle while high
//   parallelInput  in   parallel load data
//   parallelOutput out  register contents
//   serialOutput   out  register MSB
//   loaded         out  register holds loaded data not yet shifted
module shift_reg #(
    parameter int WIDTH       = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic             masterClk,
    input  logic             rst,
    input  logic             clk,
    input  logic             serialInput,
    input  logic             enableShift,
    input  logic             load,
    input  logic [WIDTH-1:0] parallelInput,
    output logic [WIDTH-1:0] parallelOutput,
    output logic             serialOutput,
    output logic             loaded
);

`ifdef SHIFTREG_INPUT_SYNC_EN
    localparam int DEPTH = SYNC_STAGES;
`else
    localparam int DEPTH = 1;
`endif

    // After reset the sampling stages hold 0 rather than the real strobe
    // level. Until they have refilled, pulses are suppressed and the edge
    // history is held at 1, so a strobe that is already high when reset
    // releases is not taken as a rising edge.
    localparam logic [7:0] WARM_INIT = 8'(SYNC_STAGES);

    logic [DEPTH-1:0] clkStages;
    logic [DEPTH-1:0] serStages;
    logic             clkHist;
    logic [7:0]       warmCnt;
    logic             warmDone;
    logic             shiftPulse;
    logic             serialIn;
    logic [WIDTH-1:0] shiftData;

    assign warmDone   = (warmCnt == 8'd0);
    assign serialIn   = serStages[DEPTH-1];
    assign shiftPulse = warmDone & clkStages[DEPTH-1] & ~clkHist;

    always_ff @(posedge masterClk) begin
        if (rst) begin
            clkStages <= '0;
            serStages <= '0;
            clkHist   <= 1'b1;
            warmCnt   <= WARM_INIT;
        end else begin
            clkStages[0] <= clk;
            serStages[0] <= serialInput;
            for (int i = 1; i < DEPTH; i++) begin
                clkStages[i] <= clkStages[i-1];
                serStages[i] <= serStages[i-1];
            end
            clkHist <= warmDone ? clkStages[DEPTH-1] : 1'b1;
            if (!warmDone) begin
                warmCnt <= warmCnt - 8'd1;
            end
        end
    end

    // Load has priority; a strobe edge arriving while load is high is lost.
    always_ff @(posedge masterClk) begin
        if (rst) begin
            shiftData <= '0;
            loaded    <= 1'b0;
        end else if (load) begin
            shiftData <= parallelInput;
            loaded    <= 1'b1;
        end else if (shiftPulse && enableShift) begin
            shiftData <= {shiftData[WIDTH-2:0], serialIn};
            loaded    <= 1'b0;
        end
    end

    assign parallelOutput = shiftData;
    assign serialOutput   = shiftData[WIDTH-1];

endmodule

// File: tb/tb_shift_reg.sv
module tb_shift_reg;

    localparam int W = 32;
    localparam int H = 8;   // strobe half period in masterClk cycles

    logic         masterClk = 1'b0;
    logic         rst;
    logic         clk;
    logic         serialInput;
    logic         enableShift;
    logic         load;
    logic [W-1:0] parallelInput;
    logic [W-1:0] parallelOutput;
    logic         serialOutput;
    logic         loaded;

    int total = 0;
    int bad   = 0;

    shift_reg #(.WIDTH(W), .SYNC_STAGES(2)) dut (
        .masterClk     (masterClk),
        .rst           (rst),
        .clk           (clk),
        .serialInput   (serialInput),
        .enableShift   (enableShift),
        .load          (load),
        .parallelInput (parallelInput),
        .parallelOutput(parallelOutput),
        .serialOutput  (serialOutput),
        .loaded        (loaded)
    );

    always #5 masterClk = ~masterClk;

    initial begin
        #500us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [W-1:0] data;
        logic [W-1:0] expPo;
        logic         expSo;
        logic         expLoaded;
    } loadVec_t;

    loadVec_t vecs[6];

    task automatic cycles(input int n);
        repeat (n) @(posedge masterClk);
        #1;
    endtask

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One strobe period per bit; serialOutput is captured at the falling
    // edge that precedes each rising edge, as downstream logic would.
    task automatic shiftWord(input logic [W-1:0] w, output logic [W-1:0] cap);
        for (int i = W - 1; i >= 0; i--) begin
            cap[i]      = serialOutput;
            clk         = 1'b0;
            serialInput = w[i];
            cycles(H);
            clk = 1'b1;
            cycles(H);
        end
    endtask

    logic [W-1:0] cap;
    logic [W-1:0] held;

    initial begin
        vecs[0] = '{32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1};
        vecs[1] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1};
        vecs[2] = '{32'h8000_0001, 32'h8000_0001, 1'b1, 1'b1};
        vecs[3] = '{32'h7FFF_FFFE, 32'h7FFF_FFFE, 1'b0, 1'b1};
        vecs[4] = '{32'hA5A5_5A5A, 32'hA5A5_5A5A, 1'b1, 1'b1};
        vecs[5] = '{32'h0F1E_2D3C, 32'h0F1E_2D3C, 1'b0, 1'b1};

        // Reset with the strobe already high and shifting enabled.
        rst = 1'b1; clk = 1'b1; serialInput = 1'b1; enableShift = 1'b1;
        load = 1'b0; parallelInput = '0;
        cycles(4);
        check("reset_po", parallelOutput, 32'h0);
        check("reset_so", {31'b0, serialOutput}, 32'h0);
        check("reset_loaded", {31'b0, loaded}, 32'h0);
        rst = 1'b0;
        cycles(20);
        check("high_at_release_no_shift", parallelOutput, 32'h0);
        clk = 1'b0;
        cycles(H);

        // Parallel load table.
        for (int i = 0; i < 6; i++) begin
            parallelInput = vecs[i].data;
            load = 1'b1;
            cycles(1);
            load = 1'b0;
            cycles(2);
            check($sformatf("load%0d_po", i), parallelOutput, vecs[i].expPo);
            check($sformatf("load%0d_so", i), {31'b0, serialOutput}, {31'b0, vecs[i].expSo});
            check($sformatf("load%0d_loaded", i), {31'b0, loaded}, {31'b0, vecs[i].expLoaded});
        end

        // 1: shift a word in MSB first.
        enableShift = 1'b1;
        shiftWord(32'h55AA_00FF, cap);
        enableShift = 1'b0;
        check("t1_po", parallelOutput, 32'h55AA_00FF);
        check("t1_loaded", {31'b0, loaded}, 32'h0);
        check("t1_cap_prev_load", cap, 32'h0F1E_2D3C);

        // 2: 100 ns load pulse, then shift out the loaded word.
        clk = 1'b0;
        cycles(H);
        parallelInput = 32'h0F1E_2D3C;
        load = 1'b1;
        cycles(10);
        load = 1'b0;
        cycles(2);
        check("t2_loaded_set", {31'b0, loaded}, 32'h1);
        check("t2_po_loaded", parallelOutput, 32'h0F1E_2D3C);
        enableShift = 1'b1;
        shiftWord(32'hFFAA_5500, cap);
        check("t2_cap", cap, 32'h0F1E_2D3C);
        check("t2_po", parallelOutput, 32'hFFAA_5500);
        check("t2_loaded_clr", {31'b0, loaded}, 32'h0);

        // 3: pass-through of consecutive words.
        shiftWord(32'hFFAA_5500, cap);
        check("t3_cap1", cap, 32'hFFAA_5500);
        shiftWord(32'hFFAA_5500, cap);
        check("t3_cap2", cap, 32'hFFAA_5500);
        shiftWord(32'hDEAD_BEEF, cap);
        shiftWord(32'h1357_9BDF, cap);
        check("t3_cap_delay", cap, 32'hDEAD_BEEF);
        check("t3_po_delay", parallelOutput, 32'h1357_9BDF);

        // 4: strobe edges with shifting disabled are dropped, not queued.
        enableShift = 1'b0;
        serialInput = 1'b1;
        for (int i = 0; i < 10; i++) begin
            clk = 1'b0; cycles(H);
            clk = 1'b1; cycles(H);
        end
        check("t4_po_hold", parallelOutput, 32'h1357_9BDF);
        enableShift = 1'b1;
        cycles(3 * H);
        check("t4_no_queue", parallelOutput, 32'h1357_9BDF);
        clk = 1'b0;
        cycles(H);

        // 5: load held across a strobe rising edge.
        parallelInput = 32'h89AB_CDEF;
        serialInput = 1'b1;
        load = 1'b1;
        cycles(2);
        clk = 1'b1;
        cycles(H);
        load = 1'b0;
        cycles(H);
        check("t5_po", parallelOutput, 32'h89AB_CDEF);
        check("t5_loaded", {31'b0, loaded}, 32'h1);
        clk = 1'b0;
        cycles(H);
        check("t5_no_deferred", parallelOutput, 32'h89AB_CDEF);

        // One real edge afterwards shifts once: {89ABCDEF[30:0], 1}.
        clk = 1'b1;
        cycles(H);
        check("t5_single_shift", parallelOutput, 32'h1357_9BDF);
        clk = 1'b0;
        cycles(H);

        // 6: reset mid-word.
        parallelInput = 32'hFFFF_FFFF;
        load = 1'b1;
        cycles(1);
        load = 1'b0;
        held = 32'h0;
        for (int i = 0; i < 10; i++) begin
            serialInput = 1'b1;
            clk = 1'b0; cycles(H);
            clk = 1'b1; cycles(H);
        end
        rst = 1'b1;
        cycles(1);
        rst = 1'b0;
        check("t6_po", parallelOutput, held);
        check("t6_so", {31'b0, serialOutput}, 32'h0);
        check("t6_loaded", {31'b0, loaded}, 32'h0);
        clk = 1'b0;
        cycles(H);
        shiftWord(32'hC3C3_3C3C, cap);
        check("t6_after_reset_cap", cap, 32'h0);
        check("t6_after_reset_po", parallelOutput, 32'hC3C3_3C3C);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
